// File: rtl/updown_counter_pkg.sv
// Shared types and helpers for the up/down counter bank.
// Helpers work on a fixed 32-bit word; callers zero-extend, so WIDTH+1 must stay within 32 bits.
package updown_counter_pkg;

    localparam int MAX_W = 32;

    typedef logic [MAX_W-1:0] word_t;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_INC,
        OP_DEC,
        OP_LOAD
    } op_e;

    function automatic logic bound_gt(input word_t a, input word_t b);
        return (a > b);
    endfunction

    function automatic word_t clamp(input word_t v, input word_t lo, input word_t hi);
        word_t r;
        r = v;
        if (bound_gt(lo, v)) begin
            r = lo;
        end else if (bound_gt(v, hi)) begin
            r = hi;
        end
        return r;
    endfunction

endpackage

// File: rtl/updown_counter_channel.sv
// One bounded up/down counter with programmable step, saturate-or-wrap mode,
// parallel load and sticky overflow/underflow flags.
module updown_counter_channel
    import updown_counter_pkg::*;
#(
    parameter int WIDTH  = 7,
    parameter int STEP_W = 4
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              cfg_err_i,
    input  logic              inc_i,
    input  logic              dec_i,
    input  logic [STEP_W-1:0] step_i,
    input  logic              wrap_en_i,
    input  logic [WIDTH-1:0]  lo_i,
    input  logic [WIDTH-1:0]  hi_i,
    input  logic              load_i,
    input  logic [WIDTH-1:0]  load_val_i,
    input  logic              flag_clr_i,
    output logic [WIDTH-1:0]  count_o,
    output logic              at_max_o,
    output logic              at_min_o,
    output logic              ovf_o,
    output logic              unf_o
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;

    op_e              op;
    logic [WIDTH:0]   step_ext;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   lo_plus_step;
    logic [WIDTH-1:0] diff;
    logic             over;
    logic             under;
    logic             ovf_set;
    logic             unf_set;

    // Extra bit keeps count+step and count-step from aliasing back into range.
    assign step_ext     = (WIDTH+1)'(step_i);
    assign sum          = {1'b0, count_q} + step_ext;
    assign lo_plus_step = {1'b0, lo_i} + step_ext;
    assign diff         = count_q - WIDTH'(step_i);
    assign over         = bound_gt(word_t'(sum), word_t'({1'b0, hi_i}));
    assign under        = bound_gt(word_t'(lo_plus_step), word_t'({1'b0, count_q}));

    always_comb begin
        op = OP_HOLD;
        if (load_i) begin
            op = OP_LOAD;
        end else if (inc_i ^ dec_i) begin
            op = inc_i ? OP_INC : OP_DEC;
        end
    end

    always_comb begin
        count_d = count_q;
        ovf_set = 1'b0;
        unf_set = 1'b0;
        unique case (op)
            OP_LOAD: begin
                count_d = WIDTH'(clamp(word_t'(load_val_i), word_t'(lo_i), word_t'(hi_i)));
            end
            OP_INC: begin
                if (step_i != '0) begin
                    if (over) begin
                        ovf_set = 1'b1;
                        count_d = wrap_en_i ? lo_i : hi_i;
                    end else begin
                        count_d = sum[WIDTH-1:0];
                    end
                end
            end
            OP_DEC: begin
                if (step_i != '0) begin
                    if (under) begin
                        unf_set = 1'b1;
                        count_d = wrap_en_i ? hi_i : lo_i;
                    end else begin
                        count_d = diff;
                    end
                end
            end
            default: begin
                count_d = count_q;
            end
        endcase

        ovf_d = ovf_set | (ovf_q & ~flag_clr_i);
        unf_d = unf_set | (unf_q & ~flag_clr_i);

        // Inverted bounds pin the count to lo and freeze the flags.
        if (cfg_err_i) begin
            count_d = lo_i;
            ovf_d   = ovf_q;
            unf_d   = unf_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            count_q <= lo_i;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign count_o  = count_q;
    assign at_max_o = (count_q == hi_i);
    assign at_min_o = (count_q == lo_i);
    assign ovf_o    = ovf_q;
    assign unf_o    = unf_q;

endmodule

// File: rtl/updown_counter_bank.sv
// Bank of independent bounded up/down counters sharing step, bounds and load value.
// Holds no state of its own: bound checking and output packing only.
module updown_counter_bank
    import updown_counter_pkg::*;
#(
    parameter int WIDTH    = 7,
    parameter int CHANNELS = 4,
    parameter int STEP_W   = 4
) (
    input  logic                      clk_i,
    input  logic                      reset_ni,
    input  logic [CHANNELS-1:0]       inc_i,
    input  logic [CHANNELS-1:0]       dec_i,
    input  logic [STEP_W-1:0]         step_i,
    input  logic [CHANNELS-1:0]       wrap_en_i,
    input  logic [WIDTH-1:0]          lo_i,
    input  logic [WIDTH-1:0]          hi_i,
    input  logic [CHANNELS-1:0]       load_i,
    input  logic [WIDTH-1:0]          load_val_i,
    input  logic [CHANNELS-1:0]       flag_clr_i,
    output logic [CHANNELS*WIDTH-1:0] count_o,
    output logic [CHANNELS-1:0]       at_max_o,
    output logic [CHANNELS-1:0]       at_min_o,
    output logic [CHANNELS-1:0]       ovf_o,
    output logic [CHANNELS-1:0]       unf_o,
    output logic                      cfg_err_o
);

    logic cfg_err;

    assign cfg_err   = bound_gt(word_t'(lo_i), word_t'(hi_i));
    assign cfg_err_o = cfg_err;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        updown_counter_channel #(
            .WIDTH  (WIDTH),
            .STEP_W (STEP_W)
        ) u_chan (
            .clk_i      (clk_i),
            .reset_ni   (reset_ni),
            .cfg_err_i  (cfg_err),
            .inc_i      (inc_i[i]),
            .dec_i      (dec_i[i]),
            .step_i     (step_i),
            .wrap_en_i  (wrap_en_i[i]),
            .lo_i       (lo_i),
            .hi_i       (hi_i),
            .load_i     (load_i[i]),
            .load_val_i (load_val_i),
            .flag_clr_i (flag_clr_i[i]),
            .count_o    (count_o[i*WIDTH +: WIDTH]),
            .at_max_o   (at_max_o[i]),
            .at_min_o   (at_min_o[i]),
            .ovf_o      (ovf_o[i]),
            .unf_o      (unf_o[i])
        );
    end

endmodule
